reg_scoreboard: RTL
===================

Name: reg_scoreboard

Overview:
- Decode-stage hazard scoreboard. Sits directly upstream of the bypassed register file.
- Tracks outstanding writes per architectural register and stalls decode when a source register has an in-flight producer.
- Same-cycle writeback relieves the stall, because the register file forwards writeData on a matching read.
- Writebacks and squash notifications from later stages retire pending entries.

Parameters:
NUM_REGS, 8, number of architectural registers
SEL_W, 3, register select width (log2 NUM_REGS)
CNT_W, 2, per-register outstanding-write counter width; max in flight per register = 2^CNT_W-1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_valid  in  1  decode holds a valid instruction
id_read1_en  in  1  instruction reads source 1
id_read1_sel  in  SEL_W  source 1 register
id_read2_en  in  1  instruction reads source 2
id_read2_sel  in  SEL_W  source 2 register
id_write_en  in  1  instruction writes a destination
id_write_sel  in  SEL_W  destination register
wb_en  in  1  WB stage writes register file this cycle
wb_sel  in  SEL_W  WB destination (same signal as register file writeRegSel)
kill_en  in  1  a squashed in-flight instruction had a destination
kill_sel  in  SEL_W  its destination
stall  out  1  hold decode/fetch this cycle
issue  out  1  instruction leaves decode this cycle
busy_vec  out  NUM_REGS  bit i = counter i nonzero (registered view)
err  out  1  sticky: underflow detected
stall_cycles  out  16  stall cycle count (see Optional Feature)

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: all counters 0, err 0, stall_cycles 0. stall and issue follow from inputs; with counters at 0 they are 0 unless id_valid makes issue=1.
- relief(s): cnt[s]==1 & wb_en & wb_sel==s.
  - A single remaining producer writing back this cycle counts as resolved, via register file bypass.
- hazN: id_readN_en & cnt[selN]!=0 & ~relief(selN).
- full: id_write_en & cnt[id_write_sel]==max. No relief for full.
- stall = id_valid & (haz1 | haz2 | full). Purely combinational, zero latency.
- issue = id_valid & ~stall.
- Per-register next count = cnt + inc - dec_wb - dec_kill. Each term is 0 or 1.
  - inc: issue & id_write_en & id_write_sel==i.
  - dec_wb: wb_en & wb_sel==i.
  - dec_kill: kill_en & kill_sel==i.
  - wb and kill on the same register in one cycle: decrement by 2.
  - inc and dec in the same cycle on the same register: net change applies, no hazard.
- Underflow: a net decrement larger than cnt.
  - Counter clamps to 0.
  - err sets and stays set until rst.
- Overflow cannot occur, because full stalls first.
- busy_vec is registered state and reflects counters after the last clock edge.
- rst mid-operation: all state clears on that edge. rst has priority over every update.
- stall does not depend on kill_en. A kill frees the entry only on the next cycle.

Optional Feature:
- Macro SCOREBOARD_STALL_STATS_EN.
- Defined: stall_cycles is a 16-bit saturating counter.
  - Increments on each cycle with stall=1.
  - Holds at 16'hFFFF.
  - Clears on rst.
- Undefined: no counter is built. stall_cycles is tied to 0.

Decomposition:
- Shared package holds:
  - NUM_REGS, SEL_W, CNT_W defaults.
  - Register select typedef.
  - Counter typedef.
- One natural sub-module: sb_counter, a single register's up/down saturating counter with underflow flag.
  - Instantiated NUM_REGS times.
  - Top level keeps the decode, hazard, relief and stall logic.

Test Plan:
- Issue write r3 (cnt[3]=1). Next cycle, read1 r3 with no wb -> stall=1, issue=0. Set wb_en, wb_sel=3 -> stall=0, issue=1, cnt[3]=0 after the edge.
- Two writes to r5 issued back-to-back (cnt=2). Read r5 with wb_en r5 -> stall=1, since relief needs cnt==1. After one wb -> cnt=1. Read with second wb -> stall=0.
- Three writes r2 (cnt=3), then a fourth write r2 -> stall=1 (full). wb r2 -> cnt=2. Fourth write then issues -> cnt=3.
- cnt[6]=2, wb_en r6 and kill_en r6 in the same cycle -> cnt[6]=0, err=0. Repeat the kill at cnt 0 -> err=1, cnt=0, err persists.
- cnt[1]=1, issue write r1 while wb r1 in the same cycle -> cnt[1] stays 1, busy_vec[1]=1.
- Build up cnt values, assert rst for one cycle -> busy_vec=0, err=0, stall_cycles=0. With the macro defined, 5 stalled cycles -> stall_cycles=5.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// Shared defaults and types for the decode-stage register hazard scoreboard.
package reg_scoreboard_pkg;
  localparam int NUM_REGS = 8;
  localparam int SEL_W    = 3;
  localparam int CNT_W    = 2;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_MAX = '1;
  localparam cnt_t CNT_ONE = cnt_t'(1);
endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode / writeback / squash bundle between the pipeline (master) and the scoreboard (slave).
interface reg_scoreboard_if #(
  parameter int NUM_REGS = reg_scoreboard_pkg::NUM_REGS,
  parameter int SEL_W    = reg_scoreboard_pkg::SEL_W
);
  logic             id_valid;
  logic             id_read1_en;
  logic [SEL_W-1:0] id_read1_sel;
  logic             id_read2_en;
  logic [SEL_W-1:0] id_read2_sel;
  logic             id_write_en;
  logic [SEL_W-1:0] id_write_sel;
  logic             wb_en;
  logic [SEL_W-1:0] wb_sel;
  logic             kill_en;
  logic [SEL_W-1:0] kill_sel;
  logic             stall;
  logic             issue;
  logic [NUM_REGS-1:0] busy_vec;
  logic             err;
  logic [15:0]      stall_cycles;

  modport master (
    output id_valid, id_read1_en, id_read1_sel, id_read2_en, id_read2_sel,
           id_write_en, id_write_sel, wb_en, wb_sel, kill_en, kill_sel,
    input  stall, issue, busy_vec, err, stall_cycles
  );

  modport slave (
    input  id_valid, id_read1_en, id_read1_sel, id_read2_en, id_read2_sel,
           id_write_en, id_write_sel, wb_en, wb_sel, kill_en, kill_sel,
    output stall, issue, busy_vec, err, stall_cycles
  );
endinterface

// File: rtl/reg_scoreboard_sb_counter.sv
// One register's outstanding-write counter: +inc, -wb, -kill per cycle, clamped at zero.
module sb_counter
  import reg_scoreboard_pkg::*;
#(
  parameter int CNT_W = reg_scoreboard_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec_wb,
  input  logic             dec_kill,
  output logic [CNT_W-1:0] cnt,
  output logic             underflow
);
  logic signed [CNT_W+1:0] sum;

  // Negative totals mean a retire arrived with no matching producer.
  function automatic logic [CNT_W-1:0] clamp_low(input logic signed [CNT_W+1:0] v);
    return v[CNT_W+1] ? '0 : v[CNT_W-1:0];
  endfunction

  always_comb begin
    sum = $signed({2'b00, cnt})
        + $signed({{(CNT_W+1){1'b0}}, inc})
        - $signed({{(CNT_W+1){1'b0}}, dec_wb})
        - $signed({{(CNT_W+1){1'b0}}, dec_kill});
    underflow = sum[CNT_W+1];
  end

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= clamp_low(sum);
  end
endmodule

// File: rtl/reg_scoreboard.sv
// Decode hazard scoreboard; define SCOREBOARD_STALL_STATS_EN to build the stall_cycles counter.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = reg_scoreboard_pkg::NUM_REGS,
  parameter int SEL_W    = reg_scoreboard_pkg::SEL_W,
  parameter int CNT_W    = reg_scoreboard_pkg::CNT_W
) (
  input logic             clk,
  input logic             rst,
  reg_scoreboard_if.slave bus
);
  localparam logic [CNT_W-1:0] MAX_CNT = '1;
  localparam logic [CNT_W-1:0] ONE_CNT = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic [NUM_REGS-1:0] inc, dec_wb, dec_kill, underflow, busy;
  logic                haz1, haz2, full, stall, issue, err;

  // A lone producer writing back now is forwarded by the register file.
  function automatic logic relief(input logic [CNT_W-1:0] c, input logic [SEL_W-1:0] s,
                                  input logic wbe, input logic [SEL_W-1:0] wbs);
    return (c == ONE_CNT) && wbe && (wbs == s);
  endfunction

  always_comb begin
    haz1  = bus.id_read1_en && (cnt[bus.id_read1_sel] != '0)
         && !relief(cnt[bus.id_read1_sel], bus.id_read1_sel, bus.wb_en, bus.wb_sel);
    haz2  = bus.id_read2_en && (cnt[bus.id_read2_sel] != '0)
         && !relief(cnt[bus.id_read2_sel], bus.id_read2_sel, bus.wb_en, bus.wb_sel);
    full  = bus.id_write_en && (cnt[bus.id_write_sel] == MAX_CNT);
    stall = bus.id_valid && (haz1 || haz2 || full);
    issue = bus.id_valid && !stall;
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_cnt
    assign inc[i]      = issue && bus.id_write_en && (bus.id_write_sel == SEL_W'(i));
    assign dec_wb[i]   = bus.wb_en && (bus.wb_sel == SEL_W'(i));
    assign dec_kill[i] = bus.kill_en && (bus.kill_sel == SEL_W'(i));
    assign busy[i]     = |cnt[i];

    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (inc[i]),
      .dec_wb    (dec_wb[i]),
      .dec_kill  (dec_kill[i]),
      .cnt       (cnt[i]),
      .underflow (underflow[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst)             err <= 1'b0;
    else if (|underflow) err <= 1'b1;
  end

`ifdef SCOREBOARD_STALL_STATS_EN
  logic [15:0] stall_cnt;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst)        stall_cnt <= '0;
    else if (stall) stall_cnt <= sat_inc16(stall_cnt);
  end

  assign bus.stall_cycles = stall_cnt;
`else
  assign bus.stall_cycles = '0;
`endif

  assign bus.stall    = stall;
  assign bus.issue    = issue;
  assign bus.busy_vec = busy;
  assign bus.err      = err;
endmodule
